// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Inter-stage pipeline register with a valid/ready handshake, synchronous
// flush and an optional one-entry skid buffer. It also counts downstream
// stall cycles for performance debug.
//
// Build option:
//   PIPE_STAGE_REG_SKID_EN  defined   -> main + skid entry (EMPTY/ONE/TWO),
//                                        in_ready is a flop output
//                           undefined -> single entry (EMPTY/FULL),
//                                        in_ready = !out_valid | out_ready
//
// Parameters:
//   PAYLOAD_W  payload width in bits (>=1)
//   CNT_W      stall counter width (>=2)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous kill of all held entries
//   in_valid   upstream offers in_data
//   in_ready   stage can accept this cycle
//   in_data    upstream payload
//   out_valid  out_data holds a live entry (flop output)
//   out_ready  downstream consumes this cycle
//   out_data   registered payload (flop output)
//   stall_cnt  saturating count of cycles with out_valid & !out_ready
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int unsigned PAYLOAD_W = 128,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [CNT_W-1:0]     stall_cnt
);

  logic                 in_xfer;
  logic                 out_xfer;
  logic [PAYLOAD_W-1:0] main_q, main_d;
  logic                 main_vld_q, main_vld_d;
  logic [CNT_W-1:0]     stall_q, stall_d;

  assign out_valid = main_vld_q;
  assign out_data  = main_q;
  assign stall_cnt = stall_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = main_vld_q & out_ready;

  // Saturating stall counter; a flush edge never counts as a stall.
  always_comb begin
    stall_d = stall_q;
    if (main_vld_q && !out_ready && !flush && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

`ifdef PIPE_STAGE_REG_SKID_EN

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PAYLOAD_W-1:0] skid_q, skid_d;
  logic                 in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;

  // Next-state and entry data; the skid only fills while main is stalled.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_d  = in_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data;
        end else if (in_xfer) begin
          skid_d  = in_data;
          state_d = ST_TWO;
        end else if (out_xfer) begin
          main_d  = '0;
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so no input can arrive.
        if (out_xfer) begin
          main_d  = skid_q;
          skid_d  = '0;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        main_d  = '0;
        skid_d  = '0;
      end
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
    main_vld_d = (state_d != ST_EMPTY);
    in_ready_d = (state_d != ST_TWO);
  end

  // Skid-only state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

`else

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Combinational from out_ready: a consumed entry frees the slot this cycle.
  assign in_ready = !main_vld_q | out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_d  = in_data;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_xfer && in_xfer) begin
          main_d = in_data;
        end else if (out_xfer) begin
          main_d  = '0;
          state_d = ST_EMPTY;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        main_d  = '0;
      end
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
    end
    main_vld_d = (state_d == ST_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

`endif

  // Main entry and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      stall_q    <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [15:0] stall_cnt;

  logic        sat_in_ready;
  logic        sat_out_valid;
  logic [7:0]  sat_out_data;
  logic [1:0]  sat_stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] bp_vals [3];
  int         idx;
  logic       acc;
  int         sat_exp [6];

  always #5 clk = ~clk;

  pipe_stage_reg #(.PAYLOAD_W(8), .CNT_W(16)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  pipe_stage_reg #(.PAYLOAD_W(8), .CNT_W(2)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (sat_in_ready),
    .in_data   (in_data),
    .out_valid (sat_out_valid),
    .out_ready (out_ready),
    .out_data  (sat_out_data),
    .stall_cnt (sat_stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Upstream source: offers bp_vals in order, advancing only on acceptance.
  task automatic step_up();
    in_valid = (idx < 3);
    in_data  = (idx < 3) ? bp_vals[idx] : 8'h00;
    #1;
    acc = in_valid & in_ready;
    @(posedge clk);
    #1;
    if (acc) idx++;
  endtask

  initial begin
    bp_vals[0] = 8'h11;
    bp_vals[1] = 8'h22;
    bp_vals[2] = 8'h33;
    sat_exp[0] = 1; sat_exp[1] = 2; sat_exp[2] = 3;
    sat_exp[3] = 3; sat_exp[4] = 3; sat_exp[5] = 3;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    idx = 0; acc = 1'b0;
    #3;
    chk("por_out_valid", 32'(out_valid), 32'd0);
    chk("por_out_data",  32'(out_data),  32'd0);
    chk("por_stall",     32'(stall_cnt), 32'd0);
    chk("por_in_ready",  32'(in_ready),  32'd1);
    #9 rst_n = 1'b1;
    tick();

    // Reset mid-stream
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    chk("mid_load_valid", 32'(out_valid), 32'd1);
    chk("mid_load_data",  32'(out_data),  32'hA5);
    tick();
    chk("mid_stall1", 32'(stall_cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",    32'(out_valid), 32'd0);
    chk("mid_rst_data",     32'(out_data),  32'd0);
    chk("mid_rst_stall",    32'(stall_cnt), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready),  32'd1);
    #2 rst_n = 1'b1;
    tick();

    // Streaming 1..4 with out_ready=1
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      #1;
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_data",  32'(out_data),  32'(i));
    end
    in_valid = 1'b0; in_data = 8'h00;
    tick();
    chk("stream_drain_valid", 32'(out_valid), 32'd0);
    chk("stream_drain_data",  32'(out_data),  32'd0);
    chk("stream_stall",       32'(stall_cnt), 32'd0);

    // Back-pressure 0x11, 0x22, 0x33
    out_ready = 1'b0; idx = 0;
    step_up();
    chk("bp_first_data", 32'(out_data), 32'h11);
`ifdef PIPE_STAGE_REG_SKID_EN
    chk("bp_in_ready_after_11", 32'(in_ready), 32'd1);
`else
    chk("bp_in_ready_after_11", 32'(in_ready), 32'd0);
`endif
    step_up();
`ifdef PIPE_STAGE_REG_SKID_EN
    chk("bp_accepted_after_e2", 32'(idx), 32'd2);
    chk("bp_in_ready_after_22", 32'(in_ready), 32'd0);
`else
    chk("bp_accepted_after_e2", 32'(idx), 32'd1);
`endif
    repeat (4) step_up();
    chk("bp_stall5",     32'(stall_cnt), 32'd5);
    chk("bp_hold_data",  32'(out_data),  32'h11);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_in_ready",   32'(in_ready),  32'd0);
`ifdef PIPE_STAGE_REG_SKID_EN
    chk("bp_held_upstream", 32'(idx), 32'd2);
`else
    chk("bp_held_upstream", 32'(idx), 32'd1);
`endif
    out_ready = 1'b1;
    step_up();
    chk("bp_out2_valid", 32'(out_valid), 32'd1);
    chk("bp_out2_data",  32'(out_data),  32'h22);
    step_up();
    chk("bp_out3_valid", 32'(out_valid), 32'd1);
    chk("bp_out3_data",  32'(out_data),  32'h33);
    step_up();
    chk("bp_end_valid", 32'(out_valid), 32'd0);
    chk("bp_end_data",  32'(out_data),  32'd0);
    chk("bp_end_stall", 32'(stall_cnt), 32'd5);

    // Flush while stalled with an input offered
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h44;
    tick();
    in_data = 8'h55;
    tick();
    chk("fl_pre_stall", 32'(stall_cnt), 32'd6);
    in_data = 8'h77; flush = 1'b1;
    #1;
    chk("fl_in_ready_full", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    chk("fl_valid",    32'(out_valid), 32'd0);
    chk("fl_data",     32'(out_data),  32'd0);
    chk("fl_in_ready", 32'(in_ready),  32'd1);
    chk("fl_stall",    32'(stall_cnt), 32'd6);
    out_ready = 1'b1;
    tick();
    chk("fl_no77_valid", 32'(out_valid), 32'd0);
    chk("fl_no77_data",  32'(out_data),  32'd0);

    // Flush discarding an accepted input
    in_valid = 1'b1; in_data = 8'h88;
    tick();
    chk("fl2_load", 32'(out_data), 32'h88);
    in_data = 8'h99; flush = 1'b1;
    #1;
    chk("fl2_in_ready", 32'(in_ready), 32'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    chk("fl2_valid", 32'(out_valid), 32'd0);
    chk("fl2_data",  32'(out_data),  32'd0);
    chk("fl2_stall", 32'(stall_cnt), 32'd6);
    tick();
    chk("fl2_no99", 32'(out_valid), 32'd0);

    // Saturation on the CNT_W=2 instance
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    chk("sat_rst", 32'(sat_stall_cnt), 32'd0);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h05;
    tick();
    in_valid = 1'b0; in_data = 8'h00;
    chk("sat_loaded", 32'(sat_out_valid), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("sat_cnt",  32'(sat_stall_cnt), 32'(sat_exp[i]));
      chk("wide_cnt", 32'(stall_cnt),     32'(i + 1));
    end
    chk("sat_hold_data", 32'(out_data), 32'h05);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register with a valid/ready handshake, synchronous flush and an optional skid buffer. It succeeds the fixed per-stage latch banks between D/E, E/M and M/W: one instance carries an arbitrary packed payload (instr, operands, pc, imm, register numbers). It supports back-pressure, so an upstream stage can be stalled without a separate hold path. It sits between any two pipeline stages and also reports downstream stall cycles for performance debug.

## Interface
Parameters:
- PAYLOAD_W, 128, width of the packed stage payload in bits (≥1).
- CNT_W, 16, width of the stall-cycle counter (≥2).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous kill of all held entries (branch/exception squash).
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  PAYLOAD_W  upstream payload.
- out_valid  out  1  out_data holds a live entry.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  PAYLOAD_W  registered payload.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Transfers:
  - An input transfer occurs at an edge where in_valid & in_ready.
  - An output transfer occurs at an edge where out_valid & out_ready.
- Storage is a main entry (drives out_data/out_valid) plus, with the skid option, one skid entry.
- Reset (rst_n=0, immediate):
  - out_valid=0, out_data=0, skid empty, stall_cnt=0.
  - in_ready=1 in both configurations.
- Flush (edge with flush=1) has priority over everything else:
  - main and skid are invalidated and their data zeroed (0 decodes as nop).
  - Any input transfer at that edge is discarded.
  - stall_cnt is unaffected.
  - in_ready during the flush cycle follows its normal rule; the discarded input counts as accepted by upstream.
- Data is held unchanged whenever an entry is valid and not consumed. Data of an invalidated entry reads 0; data does not change when the entry is not loaded.
- stall_cnt increments at each edge where out_valid=1 & out_ready=0 and flush=0, saturating at all-ones. It is cleared only by rst_n.

Without skid, states are EMPTY and FULL:
- EMPTY: an input transfer loads main and moves to FULL.
- FULL:
  - output transfer with simultaneous input transfer: main reloaded, stays FULL;
  - output transfer alone: goes to EMPTY;
  - neither: holds.
- in_ready = !out_valid | out_ready. This is a combinational path from out_ready.

With skid, states are EMPTY, ONE and TWO:
- EMPTY: an input transfer goes to ONE.
- ONE:
  - input only (out_ready=0): input goes into skid, move to TWO;
  - input and output: main reloaded, stay ONE;
  - output only: go to EMPTY.
- TWO: in_ready=0.
  - output transfer: skid moves into main, skid emptied, go to ONE;
  - otherwise hold.
- in_ready = !skid_valid, a registered signal with no combinational path from out_ready.
- Ordering is strictly FIFO. An entry never bypasses another.

## Timing
- Latency 1 cycle: data accepted at edge N is visible on out_data after edge N.
- Throughput is 1 entry/cycle while out_ready=1, in both configurations.
- With skid, upstream sees back-pressure one cycle after downstream asserts it; the skid absorbs the in-flight entry.
- out_valid and out_data are pure flop outputs.
- rst_n assertion is asynchronous. Deassertion must be synchronised externally to clk.

## Configuration
- Macro PIPE_STAGE_REG_SKID_EN:
  - Defined: the skid entry and the EMPTY/ONE/TWO machine are compiled in, and in_ready is registered.
  - Undefined: single entry, EMPTY/FULL only, and in_ready = !out_valid | out_ready (combinational).
- Port list is identical in both builds.

## Test plan
- Reset mid-stream: load 0xA5 with out_ready=0, then pulse rst_n=0 between edges -> out_valid=0, out_data=0, stall_cnt=0 immediately, in_ready=1.
- Streaming: in_valid=1 with data 1,2,3,4 on consecutive cycles and out_ready=1 -> out_data 1,2,3,4 each one cycle later, no gaps, stall_cnt=0.
- Back-pressure (skid build): send 0x11, 0x22, 0x33 with out_ready=0 -> in_ready falls after 0x22 is accepted, 0x33 is held upstream; after 5 stalled cycles out_ready=1 -> outputs 0x11, 0x22, 0x33 in order, stall_cnt=5.
- Back-pressure (no-skid build): same stimulus -> in_ready=0 while FULL and out_ready=0, then outputs 0x11, 0x22, 0x33 in order.
- Flush with simultaneous input: in state TWO, assert flush with in_valid=1 and data 0x77 -> next cycle out_valid=0, out_data=0, skid empty, 0x77 never appears, stall_cnt unchanged.
- Saturation: CNT_W=2 with out_valid=1 and out_ready=0 held for 6 cycles -> stall_cnt reads 1, 2, 3, 3, 3, 3.
